// File: rtl/lcd_ctrl_param.sv
// Image-buffer LCD controller: loads an IMG_W x IMG_H image from IROM, applies
// 2x2 window commands around a movable point, and streams the buffer to IRAM.
module lcd_ctrl_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [AW:0]   LOAD_END  = N[AW:0];
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [RW-1:0] ROW_MIN   = RW'(1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_HOME  = RW'(IMG_H / 2);
  localparam logic [CW-1:0] COL_MIN   = CW'(1);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_HOME  = CW'(IMG_W / 2);

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_AVG, S_WRITE} state_t;

  typedef enum logic [3:0] {
    C_WRITE, C_UP, C_DOWN, C_LEFT, C_RIGHT, C_MAX, C_MIN, C_AVG,
    C_CCW, C_CW, C_MIRX, C_MIRY, C_INV, C_RELOAD, C_HOME, C_NOP
  } cmd_t;

  state_t        state, next_state;
  cmd_t          cmd_q;
  logic [AW:0]   load_cnt;
  logic [AW-1:0] load_idx;
  logic [AW-1:0] wr_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW+1:0] sum_c, sum_q;
  logic [DW-1:0] avg_c;
  logic [DW-1:0] img [N];
  logic [AW-1:0] p_idx [4];
  logic [DW-1:0] win [4];
  logic [DW-1:0] nwin [4];
  logic [DW-1:0] win_max, win_min;
  logic          win_we;

  assign busy     = (state != S_IDLE);
  assign IROM_rd  = (state == S_LOAD);
  assign IROM_A   = load_cnt[AW-1:0];
  assign load_idx = AW'(load_cnt - CNT_ONE);
  assign wr_next  = IRAM_A + AW'(1);

  // Window corners: P0 top-left, P1 top-right, P2 bottom-left, P3 bottom-right.
  always_comb begin
    p_idx[0] = {row - ROW_MIN, col - COL_MIN};
    p_idx[1] = {row - ROW_MIN, col};
    p_idx[2] = {row, col - COL_MIN};
    p_idx[3] = {row, col};
    for (int k = 0; k < 4; k++) win[k] = img[p_idx[k]];
    win_max = win[0];
    win_min = win[0];
    for (int k = 1; k < 4; k++) begin
      if (win[k] > win_max) win_max = win[k];
      if (win[k] < win_min) win_min = win[k];
    end
  end

  assign sum_c = (DW+2)'(win[0]) + (DW+2)'(win[1]) + (DW+2)'(win[2]) + (DW+2)'(win[3]);
  // Adding 2 before the shift rounds half up; the max sum still fits in DW bits after >>2.
  assign avg_c = DW'((sum_q + (DW+2)'(2)) >> 2);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_we = 1'b0;
    for (int k = 0; k < 4; k++) nwin[k] = win[k];
    if (state == S_EXEC) begin
      win_we = 1'b1;
      case (cmd_q)
        C_MAX:  for (int k = 0; k < 4; k++) nwin[k] = win_max;
        C_MIN:  for (int k = 0; k < 4; k++) nwin[k] = win_min;
        C_CCW:  begin nwin[0] = win[1]; nwin[1] = win[3]; nwin[2] = win[0]; nwin[3] = win[2]; end
        C_CW:   begin nwin[0] = win[2]; nwin[1] = win[0]; nwin[2] = win[3]; nwin[3] = win[1]; end
        C_MIRX: begin nwin[0] = win[2]; nwin[1] = win[3]; nwin[2] = win[0]; nwin[3] = win[1]; end
        C_MIRY: begin nwin[0] = win[1]; nwin[1] = win[0]; nwin[2] = win[3]; nwin[3] = win[2]; end
        C_INV:  for (int k = 0; k < 4; k++) nwin[k] = ~win[k];
        default: win_we = 1'b0;
      endcase
    end else if (state == S_AVG) begin
      win_we = 1'b1;
      for (int k = 0; k < 4; k++) nwin[k] = avg_c;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_LOAD:  if (load_cnt == LOAD_END) next_state = S_IDLE;
      S_IDLE:
        if (cmd_valid) begin
          case (cmd_t'(cmd))
            C_WRITE:  next_state = S_WRITE;
            C_RELOAD: next_state = S_LOAD;
            default:  next_state = S_EXEC;
          endcase
        end
      S_EXEC:  next_state = (cmd_q == C_AVG) ? S_AVG : S_IDLE;
      S_AVG:   next_state = S_IDLE;
      S_WRITE: if (IRAM_A == LAST_ADDR) next_state = S_IDLE;
      default: next_state = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt   <= '0;
      cmd_q      <= C_NOP;
      row        <= ROW_HOME;
      col        <= COL_HOME;
      sum_q      <= '0;
      IRAM_valid <= 1'b0;
      IRAM_A     <= '0;
      IRAM_D     <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (load_cnt != LOAD_END) load_cnt <= load_cnt + CNT_ONE;
        S_IDLE:
          if (cmd_valid) begin
            cmd_q <= cmd_t'(cmd);
            done  <= 1'b0;
            if (cmd_t'(cmd) == C_WRITE) begin
              IRAM_valid <= 1'b1;
              IRAM_A     <= '0;
              IRAM_D     <= img[0];
            end
            if (cmd_t'(cmd) == C_RELOAD) load_cnt <= '0;
          end
        S_EXEC:
          case (cmd_q)
            C_UP:    if (row != ROW_MIN) row <= row - ROW_MIN;
            C_DOWN:  if (row != ROW_MAX) row <= row + ROW_MIN;
            C_LEFT:  if (col != COL_MIN) col <= col - COL_MIN;
            C_RIGHT: if (col != COL_MAX) col <= col + COL_MIN;
            C_HOME:  begin row <= ROW_HOME; col <= COL_HOME; end
            C_AVG:   sum_q <= sum_c;
            default: ;
          endcase
        S_WRITE:
          if (IRAM_A == LAST_ADDR) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
          end else begin
            IRAM_A <= wr_next;
            IRAM_D <= img[wr_next];
          end
        default: ;
      endcase
    end
  end

  // NOTE: the image buffer is left unreset; a load always refills it before any read.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && load_cnt != '0) begin
      img[load_idx] <= IROM_Q;
    end else if (win_we) begin
      img[p_idx[0]] <= nwin[0];
      img[p_idx[1]] <= nwin[1];
      img[p_idx[2]] <= nwin[2];
      img[p_idx[3]] <= nwin[3];
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param: directed scenarios plus randomized
// command sequences compared against a pixel-array reference model.
module tb_lcd_ctrl_param;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int N     = IMG_W * IMG_H;

  logic          clk, reset, cmd_valid;
  logic [3:0]    cmd;
  logic [DW-1:0] IROM_Q, IRAM_D;
  logic [AW-1:0] IROM_A, IRAM_A;
  logic          IROM_rd, IRAM_valid, busy, done;

  logic [DW-1:0] rom [N];
  logic [DW-1:0] got [N];
  int            mdl [N];
  int            mrow, mcol;
  int            checks = 0;
  int            errors = 0;

  lcd_ctrl_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(IROM_Q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
    .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) IROM_Q <= rom[IROM_A];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: the window is the 2x2 block whose bottom-right is the point.
  task automatic model_apply(input int c);
    int idx[4];
    int w[4];
    int n[4];
    int s, m;
    idx[0] = (mrow - 1) * IMG_W + (mcol - 1);
    idx[1] = idx[0] + 1;
    idx[2] = idx[0] + IMG_W;
    idx[3] = idx[2] + 1;
    for (int k = 0; k < 4; k++) begin w[k] = mdl[idx[k]]; n[k] = w[k]; end
    case (c)
      1:  if (mrow > 1) mrow--;
      2:  if (mrow < IMG_H - 1) mrow++;
      3:  if (mcol > 1) mcol--;
      4:  if (mcol < IMG_W - 1) mcol++;
      5:  begin m = w[0]; for (int k = 1; k < 4; k++) if (w[k] > m) m = w[k]; for (int k = 0; k < 4; k++) n[k] = m; end
      6:  begin m = w[0]; for (int k = 1; k < 4; k++) if (w[k] < m) m = w[k]; for (int k = 0; k < 4; k++) n[k] = m; end
      7:  begin s = w[0] + w[1] + w[2] + w[3]; for (int k = 0; k < 4; k++) n[k] = (s + 2) / 4; end
      8:  n = '{w[1], w[3], w[0], w[2]};
      9:  n = '{w[2], w[0], w[3], w[1]};
      10: n = '{w[2], w[3], w[0], w[1]};
      11: n = '{w[1], w[0], w[3], w[2]};
      12: for (int k = 0; k < 4; k++) n[k] = (1 << DW) - 1 - w[k];
      14: begin mrow = IMG_H / 2; mcol = IMG_W / 2; end
      default: ;
    endcase
    for (int k = 0; k < 4; k++) mdl[idx[k]] = n[k];
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL %s idle-wait: busy=%b after %0d cycles, expected 0", tag, busy, n);
      errors++;
    end
  endtask

  task automatic send_cmd(input int c);
    cmd       = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int c);
    wait_idle("pre-cmd");
    send_cmd(c);
    model_apply(c);
    wait_idle("cmd");
  endtask

  // Called in the first cycle of a load (right after reset release or RELOAD accept).
  task automatic check_load(input string tag);
    for (int k = 0; k <= N + 1; k++) begin
      if (k < N) begin
        checks++;
        if (IROM_A !== AW'(k)) begin
          $display("FAIL %s IROM_A cycle %0d: got %0d, expected %0d", tag, k, IROM_A, k);
          errors++;
        end
      end
      checks++;
      if (busy !== 1'(k <= N) || IROM_rd !== 1'(k <= N)) begin
        $display("FAIL %s busy/rd cycle %0d: got %b/%b, expected %b", tag, k, busy, IROM_rd, 1'(k <= N));
        errors++;
      end
      if (k <= N) @(negedge clk);
    end
    for (int i = 0; i < N; i++) mdl[i] = rom[i];
  endtask

  task automatic check_write(input string tag);
    wait_idle(tag);
    send_cmd(0);
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL %s done-clear: got %b, expected 0", tag, done);
      errors++;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (IRAM_valid !== 1'b1 || IRAM_A !== AW'(i) || IRAM_D !== DW'(mdl[i])) begin
        $display("FAIL %s beat %0d: valid=%b A=%0d D=%0d, expected valid=1 A=%0d D=%0d",
                 tag, i, IRAM_valid, IRAM_A, IRAM_D, i, mdl[i]);
        errors++;
      end
      got[i] = IRAM_D;
      @(negedge clk);
    end
    checks++;
    if (IRAM_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      $display("FAIL %s end: valid=%b busy=%b done=%b, expected 0/0/1", tag, IRAM_valid, busy, done);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd = '0;
    for (int i = 0; i < N; i++) rom[i] = DW'(i);
    repeat (3) @(negedge clk);
    checks++;
    if (IROM_rd !== 1'b1 || IROM_A !== '0 || IRAM_valid !== 1'b0 || IRAM_A !== '0 ||
        IRAM_D !== '0 || busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL reset outputs: rd=%b IA=%0d v=%b RA=%0d D=%0d busy=%b done=%b, expected 1 0 0 0 0 1 0",
               IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done);
      errors++;
    end
    mrow = IMG_H / 2;
    mcol = IMG_W / 2;
  endtask

  task automatic test_load();
    reset = 1'b1;
    check_load("load");
  endtask

  task automatic test_write();
    check_write("write");
  endtask

  task automatic test_move_max();
    int ix[4] = '{3, 4, 11, 12};
    for (int i = 0; i < 5; i++) run_cmd(1);
    run_cmd(5);
    check_write("move_max");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[ix[k]] !== 8'd12) begin
        $display("FAIL move_max buf[%0d]: got %0d, expected 12", ix[k], got[ix[k]]);
        errors++;
      end
    end
    run_cmd(1);
    run_cmd(12);
    check_write("up_saturate");
    checks++;
    if (got[3] !== 8'd243 || got[11] !== 8'd243 || got[19] !== 8'd19) begin
      $display("FAIL up_saturate: buf3=%0d buf11=%0d buf19=%0d, expected 243 243 19", got[3], got[11], got[19]);
      errors++;
    end
  endtask

  task automatic test_avg();
    int ix[4] = '{27, 28, 35, 36};
    run_cmd(14);
    send_cmd(7);
    model_apply(7);
    checks++;
    if (busy !== 1'b1) begin $display("FAIL avg busy c1: got %b, expected 1", busy); errors++; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin $display("FAIL avg busy c2: got %b, expected 1", busy); errors++; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin $display("FAIL avg busy c3: got %b, expected 0", busy); errors++; end
    check_write("avg");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[ix[k]] !== 8'd32) begin
        $display("FAIL avg buf[%0d]: got %0d, expected 32", ix[k], got[ix[k]]);
        errors++;
      end
    end
  endtask

  task automatic test_rotate_mirror();
    wait_idle("reload");
    send_cmd(13);
    check_load("reload");
    run_cmd(9);
    check_write("cw");
    checks++;
    if (got[27] !== 8'd35 || got[28] !== 8'd27 || got[35] !== 8'd36 || got[36] !== 8'd28) begin
      $display("FAIL cw window: got %0d %0d %0d %0d, expected 35 27 36 28", got[27], got[28], got[35], got[36]);
      errors++;
    end
    run_cmd(8);
    check_write("ccw");
    checks++;
    if (got[27] !== 8'd27 || got[28] !== 8'd28 || got[35] !== 8'd35 || got[36] !== 8'd36) begin
      $display("FAIL ccw restore: got %0d %0d %0d %0d, expected 27 28 35 36", got[27], got[28], got[35], got[36]);
      errors++;
    end
    run_cmd(10);
    check_write("mirror_x");
    checks++;
    if (got[27] !== 8'd35 || got[35] !== 8'd27) begin
      $display("FAIL mirror_x: buf27=%0d buf35=%0d, expected 35 27", got[27], got[35]);
      errors++;
    end
    run_cmd(12);
    check_write("invert");
    checks++;
    if (got[27] !== 8'd220) begin
      $display("FAIL invert buf27: got %0d, expected 220", got[27]);
      errors++;
    end
  endtask

  task automatic test_busy_ignore();
    wait_idle("ignore");
    send_cmd(7);
    model_apply(7);
    cmd = 4'd12;
    cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin $display("FAIL ignore idle: busy=%b, expected 0", busy); errors++; end
    check_write("busy_ignore");
  endtask

  task automatic test_random();
    int c;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) rom[i] = DW'($urandom);
      wait_idle("rand reload");
      send_cmd(13);
      check_load("rand_load");
      for (int j = 0; j < 30; j++) begin
        c = $urandom_range(1, 15);
        if (c == 13) c = 7;
        run_cmd(c);
      end
      check_write("random");
    end
  endtask

  task automatic test_reset_mid_write();
    wait_idle("mid");
    send_cmd(0);
    repeat (10) @(negedge clk);
    checks++;
    if (IRAM_A !== AW'(10) || IRAM_valid !== 1'b1) begin
      $display("FAIL midwrite beat: A=%0d valid=%b, expected 10 1", IRAM_A, IRAM_valid);
      errors++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (IRAM_valid !== 1'b0 || busy !== 1'b1 || IROM_rd !== 1'b1 || IROM_A !== '0 || done !== 1'b0) begin
      $display("FAIL midwrite reset: valid=%b busy=%b rd=%b IA=%0d done=%b, expected 0 1 1 0 0",
               IRAM_valid, busy, IROM_rd, IROM_A, done);
      errors++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_load("post_reset_load");
    mrow = IMG_H / 2;
    mcol = IMG_W / 2;
    run_cmd(5);
    check_write("post_reset");
  endtask

  initial begin
    test_reset();
    test_load();
    test_write();
    test_move_max();
    test_avg();
    test_rotate_mirror();
    test_busy_ignore();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
